// File: rtl/mem_pkg.sv
// mem_pkg: shared types for the load/store unit.
package mem_pkg;
  typedef enum logic [1:0] {BYTE, HALF, WORD, DOUBLE} op_e;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: request/response and memory-bus signals of the load/store unit.
interface mem_lsu_if #(parameter int XLEN = 32);
  logic              req_valid;
  logic              req_ready;
  logic              is_write;
  logic              is_unsigned;
  logic [1:0]        op;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [XLEN-1:0]   rdata;
  logic              op_fault;
  logic              addr_fault;
  logic              access_fault;
  logic              bus_valid;
  logic              bus_we;
  logic [XLEN-1:0]   bus_addr;
  logic [XLEN/8-1:0] bus_be;
  logic [XLEN-1:0]   bus_wdata;
  logic              bus_ready;
  logic              bus_err;
  logic [XLEN-1:0]   bus_rdata;
  modport slave (
    input  req_valid, is_write, is_unsigned, op, addr, wdata, rsp_ready, bus_ready, bus_err, bus_rdata,
    output req_ready, rsp_valid, rdata, op_fault, addr_fault, access_fault,
           bus_valid, bus_we, bus_addr, bus_be, bus_wdata
  );
  modport master (
    output req_valid, is_write, is_unsigned, op, addr, wdata, rsp_ready, bus_ready, bus_err, bus_rdata,
    input  req_ready, rsp_valid, rdata, op_fault, addr_fault, access_fault,
           bus_valid, bus_we, bus_addr, bus_be, bus_wdata
  );
endinterface

// File: rtl/mem_align.sv
// mem_align: byte-lane enables, store-data shift and load lane extraction/extension.
module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  op_e                       op_i,
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic                      uns_i,
  input  logic [XLEN-1:0]           wdata_i,
  input  logic [XLEN-1:0]           bus_rdata_i,
  output logic [XLEN/8-1:0]         be_o,
  output logic [XLEN-1:0]           wdata_o,
  output logic [XLEN-1:0]           rdata_o
);
  localparam int NB = XLEN / 8;
  localparam int SW = $clog2(XLEN);
  logic [6:0]      nbits;
  logic [7:0]      bmask;
  logic [SW-1:0]   boff;
  logic [SW-1:0]   sidx;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] m;
  assign boff    = {off_i, 3'b000};
  assign nbits   = 7'd8 << op_i;
  assign bmask   = ~(8'hFF << (4'd1 << op_i));
  assign be_o    = NB'(bmask) << off_i;
  assign wdata_o = wdata_i << boff;
  assign sh      = bus_rdata_i >> boff;
  // shifting past XLEN yields an all-ones mask, covering the full-width access
  assign m       = ~({XLEN{1'b1}} << nbits);
  assign sidx    = SW'(nbits - 7'd1);
  assign rdata_o = (sh & m) | ({XLEN{!uns_i && sh[sidx]}} & ~m);
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store unit with fault checks and bus timeout.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic      clk,
  input logic      reset_n,
  mem_lsu_if.slave io
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  state_e          state_q, state_d;
  op_e             op_q, op_d, op_in;
  logic            we_q, we_d, uns_q, uns_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            opf_q, opf_d, af_q, af_d, acc_q, acc_d;
  logic            opf, af, bus_v, rsp_v;
  logic [NB-1:0]   be;
  logic [XLEN-1:0] bwd, lrd;
  assign op_in = op_e'(io.op);
  assign opf   = op_in == DOUBLE && XLEN == 32;
  assign af    = !opf && ((op_in == HALF && io.addr[0]) ||
                          (op_in == WORD && io.addr[1:0] != 2'b00) ||
                          (op_in == DOUBLE && io.addr[2:0] != 3'b000));
  mem_align #(.XLEN(XLEN)) u_align (
    .op_i       (op_q),
    .off_i      (addr_q[LB-1:0]),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .bus_rdata_i(io.bus_rdata),
    .be_o       (be),
    .wdata_o    (bwd),
    .rdata_o    (lrd)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    we_d    = we_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    opf_d   = opf_q;
    af_d    = af_q;
    acc_d   = acc_q;
    if (state_q == IDLE) begin
      if (io.req_valid) begin
        op_d    = op_in;
        we_d    = io.is_write;
        uns_d   = io.is_unsigned;
        addr_d  = io.addr;
        wdata_d = io.wdata;
        opf_d   = opf;
        af_d    = af;
        acc_d   = 1'b0;
        rdata_d = '0;
        cnt_d   = 8'd0;
        state_d = (opf || af) ? RESP : BUS;
      end
    end else if (state_q == BUS) begin
      // completion wins over a timeout reached in the same cycle
      if (io.bus_ready) begin
        state_d = RESP;
        acc_d   = io.bus_err;
        rdata_d = we_q ? '0 : lrd;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d = RESP;
        acc_d   = 1'b1;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (state_q == RESP && io.rsp_ready) begin
      state_d = IDLE;
      opf_d   = 1'b0;
      af_d    = 1'b0;
      acc_d   = 1'b0;
      rdata_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= BYTE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 8'd0;
      opf_q   <= 1'b0;
      af_q    <= 1'b0;
      acc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      opf_q   <= opf_d;
      af_q    <= af_d;
      acc_q   <= acc_d;
    end
  end
  assign bus_v           = state_q == BUS;
  assign rsp_v           = state_q == RESP;
  assign io.req_ready    = state_q == IDLE;
  assign io.bus_valid    = bus_v;
  assign io.bus_we       = bus_v && we_q;
  assign io.bus_addr     = bus_v ? {addr_q[XLEN-1:LB], {LB{1'b0}}} : '0;
  assign io.bus_be       = bus_v ? be : '0;
  assign io.bus_wdata    = bus_v ? bwd : '0;
  assign io.rsp_valid    = rsp_v;
  assign io.rdata        = rsp_v ? rdata_q : '0;
  assign io.op_fault     = rsp_v && opf_q;
  assign io.addr_fault   = rsp_v && af_q;
  assign io.access_fault = rsp_v && acc_q;
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed vector table plus timeout, bus-error and reset sequences.
module tb_mem_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rn32, rn64;
  mem_lsu_if #(.XLEN(32)) i32 ();
  mem_lsu_if #(.XLEN(64)) i64 ();
  mem_lsu #(.XLEN(32), .TIMEOUT(4)) u32 (.clk(clk), .reset_n(rn32), .io(i32.slave));
  mem_lsu #(.XLEN(64)) u64 (.clk(clk), .reset_n(rn64), .io(i64.slave));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic        we, uns;
    logic [1:0]  op;
    logic [31:0] addr, wdata, brd;
    logic        opf, af;
    logic [3:0]  be;
    logic [31:0] baddr, bwd, rd;
    int          lat;
  } vec_t;
  vec_t v[14];
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic req32(input logic we, input logic uns, input logic [1:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata);
    i32.is_write = we; i32.is_unsigned = uns; i32.op = op;
    i32.addr = addr; i32.wdata = wdata; i32.req_valid = 1'b1;
    @(posedge clk); #1 i32.req_valid = 1'b0;
  endtask
  task automatic req64(input logic [1:0] op, input logic [63:0] addr);
    i64.is_write = 1'b0; i64.is_unsigned = 1'b0; i64.op = op;
    i64.addr = addr; i64.wdata = '0; i64.req_valid = 1'b1;
    @(posedge clk); #1 i64.req_valid = 1'b0;
  endtask
  task automatic run(input vec_t t);
    int lat;
    logic saw;
    lat = 0; saw = 1'b0;
    i32.bus_rdata = t.brd;
    req32(t.we, t.uns, t.op, t.addr, t.wdata);
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (i32.bus_valid) begin
        saw = 1'b1;
        chk("bus_addr", 64'(i32.bus_addr), 64'(t.baddr));
        chk("bus_be", 64'(i32.bus_be), 64'(t.be));
        chk("bus_we", 64'(i32.bus_we), 64'(t.we));
        if (t.we) chk("bus_wdata", 64'(i32.bus_wdata), 64'(t.bwd));
      end
      if (i32.rsp_valid) lat = c;
    end
    chk("saw_bus", 64'(saw), 64'(!(t.opf || t.af)));
    chk("latency", 64'(lat), 64'(t.lat));
    chk("rdata", 64'(i32.rdata), 64'(t.rd));
    chk("op_fault", 64'(i32.op_fault), 64'(t.opf));
    chk("addr_fault", 64'(i32.addr_fault), 64'(t.af));
    chk("access_fault", 64'(i32.access_fault), 64'd0);
    @(negedge clk);
    chk("req_ready_after", 64'(i32.req_ready), 64'd1);
    chk("rsp_valid_after", 64'(i32.rsp_valid), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int nb, lat;
    rn32 = 1'b0; rn64 = 1'b0;
    i32.req_valid = 1'b0; i32.is_write = 1'b0; i32.is_unsigned = 1'b0; i32.op = 2'd0;
    i32.addr = '0; i32.wdata = '0; i32.rsp_ready = 1'b1; i32.bus_ready = 1'b1;
    i32.bus_err = 1'b0; i32.bus_rdata = '0;
    i64.req_valid = 1'b0; i64.is_write = 1'b0; i64.is_unsigned = 1'b0; i64.op = 2'd0;
    i64.addr = '0; i64.wdata = '0; i64.rsp_ready = 1'b1; i64.bus_ready = 1'b1;
    i64.bus_err = 1'b0; i64.bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(i32.req_ready), 64'd1);
    chk("rst_bus_valid", 64'(i32.bus_valid), 64'd0);
    chk("rst_rsp_valid", 64'(i32.rsp_valid), 64'd0);
    chk("rst_rdata", 64'(i32.rdata), 64'd0);
    chk("rst_faults", 64'({i32.op_fault, i32.addr_fault, i32.access_fault}), 64'd0);
    chk("rst_bus_be", 64'(i32.bus_be), 64'd0);
    rn32 = 1'b1; rn64 = 1'b1;
    @(negedge clk);
    v[0]  = '{1'b0, 1'b0, 2'd0, 32'h1003, 32'h0, 32'h80FF_0000, 1'b0, 1'b0, 4'b1000, 32'h1000, 32'h0, 32'hFFFF_FF80, 2};
    v[1]  = '{1'b1, 1'b0, 2'd1, 32'h2002, 32'h0000_ABCD, 32'h0, 1'b0, 1'b0, 4'b1100, 32'h2000, 32'hABCD_0000, 32'h0, 2};
    v[2]  = '{1'b0, 1'b0, 2'd2, 32'h0006, 32'h0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
    v[3]  = '{1'b0, 1'b0, 2'd3, 32'h0000, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
    v[4]  = '{1'b0, 1'b0, 2'd3, 32'h0003, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
    v[5]  = '{1'b0, 1'b1, 2'd1, 32'h0102, 32'h0, 32'h8234_5678, 1'b0, 1'b0, 4'b1100, 32'h0100, 32'h0, 32'h0000_8234, 2};
    v[6]  = '{1'b0, 1'b0, 2'd1, 32'h0102, 32'h0, 32'h8234_5678, 1'b0, 1'b0, 4'b1100, 32'h0100, 32'h0, 32'hFFFF_8234, 2};
    v[7]  = '{1'b0, 1'b0, 2'd2, 32'h0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0100, 32'h0, 32'hDEAD_BEEF, 2};
    v[8]  = '{1'b1, 1'b0, 2'd0, 32'h0005, 32'h1234_5677, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'b0010, 32'h0004, 32'h3456_7700, 32'h0, 2};
    v[9]  = '{1'b0, 1'b1, 2'd0, 32'h0001, 32'h0, 32'h0000_9A00, 1'b0, 1'b0, 4'b0010, 32'h0000, 32'h0, 32'h0000_009A, 2};
    v[10] = '{1'b0, 1'b0, 2'd1, 32'h0001, 32'h0, 32'h0, 1'b0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 1};
    v[11] = '{1'b0, 1'b0, 2'd0, 32'h0000, 32'h0, 32'h0000_007F, 1'b0, 1'b0, 4'b0001, 32'h0000, 32'h0, 32'h0000_007F, 2};
    v[12] = '{1'b1, 1'b0, 2'd2, 32'h0008, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0, 4'b1111, 32'h0008, 32'hCAFE_F00D, 32'h0, 2};
    v[13] = '{1'b0, 1'b0, 2'd0, 32'h0012, 32'h0, 32'h0080_0000, 1'b0, 1'b0, 4'b0100, 32'h0010, 32'h0, 32'hFFFF_FF80, 2};
    for (int i = 0; i < 14; i++) run(v[i]);
    // timeout with bus_ready held low
    i32.bus_ready = 1'b0; i32.bus_rdata = 32'hFFFF_FFFF;
    req32(1'b0, 1'b0, 2'd2, 32'h40, 32'h0);
    nb = 0; lat = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (i32.bus_valid) nb++;
      if (i32.rsp_valid) lat = c;
    end
    chk("to_bus_cycles", 64'(nb), 64'd4);
    chk("to_latency", 64'(lat), 64'd5);
    chk("to_access_fault", 64'(i32.access_fault), 64'd1);
    chk("to_rdata", 64'(i32.rdata), 64'd0);
    chk("to_bus_valid", 64'(i32.bus_valid), 64'd0);
    @(negedge clk);
    // ready arrives in the same cycle the timeout would fire
    i32.bus_rdata = 32'h1234_5678;
    req32(1'b0, 1'b0, 2'd2, 32'h44, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("race_bus_valid", 64'(i32.bus_valid), 64'd1);
      if (c == 4) i32.bus_ready = 1'b1;
    end
    @(negedge clk);
    chk("race_rsp_valid", 64'(i32.rsp_valid), 64'd1);
    chk("race_access_fault", 64'(i32.access_fault), 64'd0);
    chk("race_rdata", 64'(i32.rdata), 64'h1234_5678);
    @(negedge clk);
    // bus error with a stalled response consumer
    i32.bus_err = 1'b1; i32.rsp_ready = 1'b0;
    req32(1'b1, 1'b0, 2'd2, 32'h80, 32'h5555_AAAA);
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("err_rsp_valid", 64'(i32.rsp_valid), 64'd1);
      chk("err_access_fault", 64'(i32.access_fault), 64'd1);
      chk("err_req_ready", 64'(i32.req_ready), 64'd0);
      if (k == 3) i32.rsp_ready = 1'b1;
    end
    i32.bus_err = 1'b0;
    @(negedge clk);
    chk("err_req_ready_after", 64'(i32.req_ready), 64'd1);
    chk("err_rsp_valid_after", 64'(i32.rsp_valid), 64'd0);
    chk("err_fault_cleared", 64'(i32.access_fault), 64'd0);
    // XLEN=64 double load
    i64.bus_rdata = 64'h8000_0000_0000_0001;
    req64(2'd3, 64'h10);
    @(negedge clk);
    chk("d64_bus_valid", 64'(i64.bus_valid), 64'd1);
    chk("d64_bus_be", 64'(i64.bus_be), 64'hFF);
    chk("d64_bus_addr", i64.bus_addr, 64'h10);
    @(negedge clk);
    chk("d64_rsp_valid", 64'(i64.rsp_valid), 64'd1);
    chk("d64_rdata", i64.rdata, 64'h8000_0000_0000_0001);
    chk("d64_op_fault", 64'(i64.op_fault), 64'd0);
    @(negedge clk);
    req64(2'd3, 64'h14);
    @(negedge clk);
    chk("d64_mis_rsp_valid", 64'(i64.rsp_valid), 64'd1);
    chk("d64_mis_faults", 64'({i64.op_fault, i64.addr_fault}), 64'b01);
    @(negedge clk);
    // reset in the middle of a bus wait
    i64.bus_ready = 1'b0;
    req64(2'd2, 64'h20);
    @(negedge clk);
    chk("rst64_bus_valid_before", 64'(i64.bus_valid), 64'd1);
    rn64 = 1'b0;
    @(negedge clk);
    chk("rst64_bus_valid", 64'(i64.bus_valid), 64'd0);
    chk("rst64_rsp_valid", 64'(i64.rsp_valid), 64'd0);
    rn64 = 1'b1; i64.bus_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (i64.rsp_valid || i64.bus_valid) nb++;
    end
    chk("rst64_no_response", 64'(nb), 64'd0);
    chk("rst64_req_ready", 64'(i64.req_ready), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter TIMEOUT, default 16, meaning maximum bus wait cycles before an access fault; legal range 1..255.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 is_write, is_unsigned  input  1 each  store select; zero-extend (vs sign-extend) loads.
REQ-008 op  input  2  access size: 00=byte, 01=half, 10=word, 11=double.
REQ-009 addr, wdata  input  XLEN each  byte address; store data (LSB-justified).
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rdata  output  XLEN  load result.
REQ-013 op_fault, addr_fault, access_fault  output  1 each  invalid size; misaligned; bus error or timeout.
REQ-014 bus_valid, bus_we  output  1 each  bus request; write strobe.
REQ-015 bus_addr  output  XLEN  addr with low log2(XLEN/8) bits forced to 0.
REQ-016 bus_be  output  XLEN/8  byte-lane enables.
REQ-017 bus_wdata  output  XLEN  lane-aligned store data.
REQ-018 bus_ready, bus_err  input  1 each  bus completion; completion carries error.
REQ-019 bus_rdata  input  XLEN  full aligned bus word.

Function
REQ-020 SHALL implement FSM IDLE, BUS, RESP; req_ready=1 only in IDLE; rsp_valid=1 only in RESP; bus_valid=1 only in BUS.
REQ-021 Accept occurs at an edge with req_valid & req_ready; all request fields SHALL be captured into registers then.
REQ-022 op_fault SHALL be set when op=11 and XLEN=32.
REQ-023 addr_fault SHALL be set when (half and addr[0]) or (word and addr[1:0]!=0) or (double and addr[2:0]!=0), and only if op_fault is clear.
REQ-024 A faulting request SHALL go IDLE->RESP with no bus transaction; rsp_valid asserted the cycle after accept.
REQ-025 A non-faulting request SHALL go IDLE->BUS; bus_valid asserted the cycle after accept; bus_addr, bus_we, bus_be, bus_wdata SHALL stay stable while bus_valid=1.
REQ-026 bus_be SHALL have 1/2/4/8 consecutive ones starting at lane addr mod (XLEN/8); bus_wdata SHALL be wdata shifted left by 8*(addr mod XLEN/8).
REQ-027 At an edge with bus_valid & bus_ready, FSM SHALL go BUS->RESP, capturing access_fault=bus_err and, for loads, the selected lanes of bus_rdata.
REQ-028 Load rdata SHALL be the selected lanes right-justified, zero-extended if is_unsigned else sign-extended; store and faulting responses SHALL give rdata=0.
REQ-029 A wait counter SHALL clear on entry to BUS and increment per BUS cycle without bus_ready; when it reaches TIMEOUT, FSM SHALL go to RESP with access_fault=1, rdata=0, and bus_valid deasserted.
REQ-030 A simultaneous bus_ready and timeout SHALL be treated as completion, not timeout.
REQ-031 RESP SHALL hold rsp_valid and all response outputs stable until rsp_ready, then go to IDLE; req_ready SHALL rise the cycle after the rsp handshake (no same-cycle re-accept).
REQ-032 Fault outputs and rdata SHALL be 0 whenever rsp_valid=0.
REQ-033 Minimum latency accept->rsp_valid SHALL be 1 cycle (fault) and 2 cycles (zero-wait bus).

Reset
REQ-034 reset_n=0 at an edge SHALL force IDLE, counter=0, and all outputs 0 except req_ready=1 from the following cycle.
REQ-035 Reset in BUS or RESP SHALL abandon the transaction with no response; bus_valid=0 the cycle after the reset edge.

Structure
REQ-036 Package mem_pkg SHALL hold the op-size enum (BYTE, HALF, WORD, DOUBLE) and the FSM state enum.
REQ-037 Lane selection and extension SHALL be in one combinational sub-module, mem_align, shared by the load path and store path.

Verification
REQ-038 XLEN=32: load byte addr 0x1003, bus_rdata 0x80FF_0000, is_unsigned=0, zero-wait -> rsp_valid at cycle 2, rdata 0xFFFF_FF80, bus_be 4'b1000.
REQ-039 XLEN=32: store half addr 0x2002, wdata 0x0000_ABCD -> bus_addr 0x2000, bus_be 4'b1100, bus_wdata 0xABCD_0000, bus_we=1.
REQ-040 XLEN=32: word at addr 0x0006 -> addr_fault=1, no bus_valid, rsp_valid at cycle 1; op=11 -> op_fault=1, addr_fault=0.
REQ-041 TIMEOUT=4, bus_ready held 0 -> bus_valid for exactly 4 cycles, then rsp_valid with access_fault=1, rdata=0.
REQ-042 bus_err=1 with bus_ready, then rsp_ready held 0 for 3 cycles -> access_fault=1 held stable 4 cycles; req_ready=1 the cycle after the handshake.
REQ-043 XLEN=64: load double addr 0x10, bus_rdata 0x8000_0000_0000_0001 -> rdata unchanged; reset asserted mid-BUS -> no rsp_valid, bus_valid=0 the next cycle.
